// File: rtl/m_data_mem_stage.sv
// m_data_mem_stage: memory-stage data memory sitting between EX/MEM and MEM/WB.
// Each access lasts MEM_LATENCY cycles. stallM holds the pipeline until the
// completing cycle. In that cycle a load returns its data combinationally and
// a store writes on the closing edge.
// Optional feature: define DMEM_MISALIGN_CHK_EN to add the misalignM port and
// suppress misaligned requests.
module m_data_mem_stage #(
    parameter int unsigned DEPTH       = 256,
    parameter int unsigned MEM_LATENCY = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        memreadM,
    input  logic        memwriteM,
    input  logic [31:0] aluoutM,
    input  logic [31:0] writedataM,
    output logic [31:0] readdata,
    output logic        stallM
`ifdef DMEM_MISALIGN_CHK_EN
    ,
    output logic        misalignM
`endif
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(MEM_LATENCY - 1);

    typedef enum logic {
        IDLE,
        WAIT
    } state_t;

    logic [31:0]   mem [DEPTH];
    logic [CW-1:0] cnt;
    state_t        state;
    logic          misaligned;
    logic          req;
    logic          complete;
    logic          in_range;
    logic [AW-1:0] idx;

    // Classify the request: alignment, range, word index and access phase.
    always_comb begin
        misaligned = 1'b0;
`ifdef DMEM_MISALIGN_CHK_EN
        misalignM  = ~reset & (memreadM | memwriteM) & (aluoutM[1:0] != 2'b00);
        misaligned = misalignM;
`endif
        // Gating with reset keeps stallM and readdata low while reset is high.
        // It also aborts any store that is still in flight.
        req      = ~reset & (memreadM | memwriteM) & ~misaligned;
        in_range = ((aluoutM >> (AW + 2)) == 32'd0);
        idx      = aluoutM[AW+1:2];
        state    = (cnt == '0) ? IDLE : WAIT;
        stallM   = req & (cnt != CNT_LAST);
        complete = req & ~stallM;
    end

    // Load data appears only in the completing cycle. A read combined with a write is treated as a store.
    always_comb begin
        readdata = '0;
        if (complete && memreadM && !memwriteM && in_range)
            readdata = mem[idx];
    end

    // Access counter: advance while stalling, otherwise return to IDLE.
    always_ff @(posedge clk) begin
        if (reset)
            cnt <= '0;
        else if (req && stallM)
            cnt <= (state == IDLE) ? CW'(1) : cnt + CW'(1);
        else
            cnt <= '0;
    end

    // A store commits once, on the edge that ends its completing cycle. Reset does not clear the memory.
    always_ff @(posedge clk) begin
        if (complete && memwriteM && in_range)
            mem[idx] <= writedataM;
    end

endmodule

// File: tb/tb_m_data_mem_stage.sv
// Directed bench for m_data_mem_stage. Three instances with latencies 1, 2
// and 4 share the same request inputs. Each step checks only the instance
// that the step targets.
module tb_m_data_mem_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        memreadM, memwriteM;
    logic [31:0] aluoutM, writedataM;
    logic [31:0] rd1, rd2, rd4;
    logic        st1, st2, st4;
`ifdef DMEM_MISALIGN_CHK_EN
    logic        ma1, ma2, ma4;
`endif

    int n_pass  = 0;
    int n_check = 0;

    always #5 clk = ~clk;

    m_data_mem_stage #(.DEPTH(256), .MEM_LATENCY(1)) u1 (
        .clk(clk), .reset(reset), .memreadM(memreadM), .memwriteM(memwriteM),
        .aluoutM(aluoutM), .writedataM(writedataM), .readdata(rd1), .stallM(st1)
`ifdef DMEM_MISALIGN_CHK_EN
        , .misalignM(ma1)
`endif
    );

    m_data_mem_stage #(.DEPTH(256), .MEM_LATENCY(2)) u2 (
        .clk(clk), .reset(reset), .memreadM(memreadM), .memwriteM(memwriteM),
        .aluoutM(aluoutM), .writedataM(writedataM), .readdata(rd2), .stallM(st2)
`ifdef DMEM_MISALIGN_CHK_EN
        , .misalignM(ma2)
`endif
    );

    m_data_mem_stage #(.DEPTH(256), .MEM_LATENCY(4)) u4 (
        .clk(clk), .reset(reset), .memreadM(memreadM), .memwriteM(memwriteM),
        .aluoutM(aluoutM), .writedataM(writedataM), .readdata(rd4), .stallM(st4)
`ifdef DMEM_MISALIGN_CHK_EN
        , .misalignM(ma4)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_check++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Apply a request just after a rising edge, then move to the falling edge for sampling.
    task automatic drive(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
        @(posedge clk);
        #1;
        memreadM   = r;
        memwriteM  = w;
        aluoutM    = a;
        writedataM = d;
        @(negedge clk);
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    initial begin
        reset = 1'b1;
        memreadM = 1'b0; memwriteM = 1'b0; aluoutM = '0; writedataM = '0;
        @(negedge clk);
        chk("rst_stall2", 32'(st2), 32'd0);
        chk("rst_rd2", rd2, 32'h0);
        chk("rst_cnt4", 32'(u4.cnt), 32'd0);
        @(posedge clk); #1 reset = 1'b0;

        // Latency 2: store, then load the same word.
        drive(1'b0, 1'b1, 32'h10, 32'h12345678);
        chk("t1_sw_c1_stall", 32'(st2), 32'd1);
        chk("t1_sw_c1_rd", rd2, 32'h0);
        drive(1'b0, 1'b1, 32'h10, 32'h12345678);
        chk("t1_sw_c2_stall", 32'(st2), 32'd0);
        drive(1'b1, 1'b0, 32'h10, 32'h0);
        chk("t1_lw_c1_stall", 32'(st2), 32'd1);
        chk("t1_lw_c1_rd", rd2, 32'h0);
        drive(1'b1, 1'b0, 32'h10, 32'h0);
        chk("t1_lw_c2_stall", 32'(st2), 32'd0);
        chk("t1_lw_c2_rd", rd2, 32'h12345678);
        idle();
        chk("t1_idle_rd", rd2, 32'h0);

        // Latency 1: a store followed by a load with no stall.
        drive(1'b0, 1'b1, 32'h4, 32'hDEADBEEF);
        chk("t2_sw_stall", 32'(st1), 32'd0);
        drive(1'b1, 1'b0, 32'h4, 32'h0);
        chk("t2_lw_stall", 32'(st1), 32'd0);
        chk("t2_lw_rd", rd1, 32'hDEADBEEF);
        idle();

        // An out-of-range store and load must leave mem[0] untouched.
        drive(1'b0, 1'b1, 32'h0, 32'h11111111);
        drive(1'b0, 1'b1, 32'h0, 32'h11111111);
        idle();
        drive(1'b0, 1'b1, 32'h400, 32'hFFFFFFFF);
        chk("t3_oor_sw_c1_stall", 32'(st2), 32'd1);
        drive(1'b0, 1'b1, 32'h400, 32'hFFFFFFFF);
        chk("t3_oor_sw_c2_stall", 32'(st2), 32'd0);
        drive(1'b1, 1'b0, 32'h400, 32'h0);
        chk("t3_oor_lw_c1_stall", 32'(st2), 32'd1);
        drive(1'b1, 1'b0, 32'h400, 32'h0);
        chk("t3_oor_lw_c2_rd", rd2, 32'h0);
        drive(1'b1, 1'b0, 32'h0, 32'h0);
        drive(1'b1, 1'b0, 32'h0, 32'h0);
        chk("t3_mem0_rd", rd2, 32'h11111111);
        idle();

        // A store dropped before it completes must not write.
        drive(1'b0, 1'b1, 32'h10, 32'h00000077);
        chk("drop_c1_stall", 32'(st2), 32'd1);
        idle();
        chk("drop_idle_stall", 32'(st2), 32'd0);
        drive(1'b1, 1'b0, 32'h10, 32'h0);
        drive(1'b1, 1'b0, 32'h10, 32'h0);
        chk("drop_lw_rd", rd2, 32'h12345678);
        idle();

        // Latency 4: store an old value, then reset a second store part-way through.
        drive(1'b0, 1'b1, 32'h8, 32'h0BADF00D);
        chk("t4_old_c1_stall", 32'(st4), 32'd1);
        drive(1'b0, 1'b1, 32'h8, 32'h0BADF00D);
        chk("t4_old_c2_stall", 32'(st4), 32'd1);
        drive(1'b0, 1'b1, 32'h8, 32'h0BADF00D);
        chk("t4_old_c3_stall", 32'(st4), 32'd1);
        drive(1'b0, 1'b1, 32'h8, 32'h0BADF00D);
        chk("t4_old_c4_stall", 32'(st4), 32'd0);
        idle();
        drive(1'b0, 1'b1, 32'h8, 32'hA5A5A5A5);
        chk("t4_new_c1_stall", 32'(st4), 32'd1);
        @(posedge clk); #1 reset = 1'b1;
        @(negedge clk);
        chk("t4_rst_stall", 32'(st4), 32'd0);
        chk("t4_rst_rd", rd4, 32'h0);
        @(posedge clk); #1 reset = 1'b0;
        memreadM = 1'b0; memwriteM = 1'b0;
        @(negedge clk);
        chk("t4_after_cnt", 32'(u4.cnt), 32'd0);
        chk("t4_after_stall", 32'(st4), 32'd0);
        drive(1'b1, 1'b0, 32'h8, 32'h0);
        drive(1'b1, 1'b0, 32'h8, 32'h0);
        drive(1'b1, 1'b0, 32'h8, 32'h0);
        chk("t4_lw_c3_rd", rd4, 32'h0);
        drive(1'b1, 1'b0, 32'h8, 32'h0);
        chk("t4_lw_c4_rd", rd4, 32'h0BADF00D);
        idle();

        // A simultaneous read and write behaves as a store.
        drive(1'b1, 1'b1, 32'hC, 32'h55);
        chk("t5_rw_c1_rd", rd2, 32'h0);
        drive(1'b1, 1'b1, 32'hC, 32'h55);
        chk("t5_rw_c2_stall", 32'(st2), 32'd0);
        chk("t5_rw_c2_rd", rd2, 32'h0);
        drive(1'b1, 1'b0, 32'hC, 32'h0);
        drive(1'b1, 1'b0, 32'hC, 32'h0);
        chk("t5_lw_rd", rd2, 32'h55);
        idle();

`ifdef DMEM_MISALIGN_CHK_EN
        // A misaligned request is flagged and suppressed.
        drive(1'b1, 1'b0, 32'h11, 32'h0);
        chk("t6_lw_mis", 32'(ma2), 32'd1);
        chk("t6_lw_stall", 32'(st2), 32'd0);
        chk("t6_lw_rd", rd2, 32'h0);
        drive(1'b0, 1'b1, 32'h12, 32'h99);
        chk("t6_sw_mis", 32'(ma2), 32'd1);
        drive(1'b0, 1'b1, 32'h12, 32'h99);
        idle();
        chk("t6_idle_mis", 32'(ma2), 32'd0);
        drive(1'b1, 1'b0, 32'h10, 32'h0);
        drive(1'b1, 1'b0, 32'h10, 32'h0);
        chk("t6_nowrite_rd", rd2, 32'h12345678);
        idle();
`endif

        $display("%0d/%0d checks passed", n_pass, n_check);
        $finish;
    end

endmodule
